// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Command-driven controller for an external combinational W-bit ALU.
//   Each accepted command runs one single-cycle ALU operation, or a W-iteration
//   unsigned shift-add multiply built from ALU adds. Results are returned over
//   a valid/ready response channel. Every output is a register or a decode of
//   the state register, so there is no input-to-output combinational path.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_mul              1 = multiply cmd_a*cmd_b, 0 = single ALU op
//   cmd_sel, cmd_cin     ALU select / carry-in for a single op
//   cmd_a, cmd_b         operands (multiplicand / multiplier)
//   alu_a/b/s/cin        ALU operand, select and carry-in lines
//   alu_y, alu_cout      ALU result and arithmetic carry-out
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             2W-bit result
//   rsp_err              multiply requested while MUL_EN = 0
module alu_mul_sequencer #(
  parameter int unsigned W      = 4,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_mul,
  input  logic [3:0]     cmd_sel,
  input  logic           cmd_cin,
  input  logic [W-1:0]   cmd_a,
  input  logic [W-1:0]   cmd_b,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [3:0]     alu_s,
  output logic           alu_cin,
  input  logic [W-1:0]   alu_y,
  input  logic           alu_cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [2*W-1:0] rsp_data,
  output logic           rsp_err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [3:0] SEL_ADD  = 4'b0000;  // A + B + cin
  localparam logic [3:0] SEL_PASS = 4'b0010;  // A + cin

  typedef enum logic [1:0] {IDLE, OP, MUL, RSP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  // Multiplier shift register. Bit 0 of the multiplier is already consumed
  // into alu_s when an iteration starts, so only bits [W-1:1] are kept.
  logic [W-1:1]    lo;
  logic            last_iter;
  logic            accept;
  logic            op_carry;
  logic [2*W-1:0]  prod_nxt;

  assign last_iter = (cnt == CW'(W - 1));
  assign accept    = (state == IDLE) && cmd_valid;
  // Carry-out is only meaningful for the arithmetic group.
  assign op_carry  = (alu_s[3:2] == 2'b00) && alu_cout;
  // {hi,lo} after this iteration: {alu_cout, alu_y, lo} shifted right by one.
  // hi lives in alu_a, which always drives the running partial sum.
  assign prod_nxt  = {alu_cout, alu_y, lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!cmd_mul)    state_nxt = OP;
          else if (MUL_EN) state_nxt = MUL;
          else             state_nxt = RSP;
        end
      end
      OP:  state_nxt = RSP;
      MUL: if (last_iter) state_nxt = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      alu_cin  <= 1'b0;
      lo       <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!cmd_mul) begin
              alu_a   <= cmd_a;
              alu_b   <= cmd_b;
              alu_s   <= cmd_sel;
              alu_cin <= cmd_cin;
            end else if (MUL_EN) begin
              alu_a   <= '0;
              alu_b   <= cmd_a;
              alu_s   <= cmd_b[0] ? SEL_ADD : SEL_PASS;
              alu_cin <= 1'b0;
              lo      <= cmd_b[W-1:1];
              cnt     <= '0;
            end else begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end
          end
        end
        OP: begin
          rsp_data <= {{(W-1){1'b0}}, op_carry, alu_y};
        end
        MUL: begin
          if (last_iter) begin
            // ALU lines are left as driven during the final iteration.
            rsp_data <= prod_nxt;
            cnt      <= '0;
          end else begin
            alu_a <= prod_nxt[2*W-1:W];
            lo    <= prod_nxt[W-1:1];
            alu_s <= prod_nxt[0] ? SEL_ADD : SEL_PASS;
            cnt   <= cnt + 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_err <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_s   <= '0;
            alu_cin <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: one instance with multiply enabled, one
// with MUL_EN = 0, each wired to a behavioural 4-bit ALU. Expected responses
// are queued when a command is sent and popped when the response arrives.
module tb_alu_mul_sequencer;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         cmd_mul = 1'b0;
  logic [3:0]   cmd_sel = '0;
  logic         cmd_cin = 1'b0;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;

  logic         v0 = 1'b0, rr0 = 1'b0, rdy0, rv0, re0, cin0, cout0;
  logic [W-1:0] a0, b0, y0;
  logic [3:0]   s0;
  logic [7:0]   rd0;

  logic         v1 = 1'b0, rr1 = 1'b0, rdy1, rv1, re1, cin1, cout1;
  logic [W-1:0] a1, b1, y1;
  logic [3:0]   s1;
  logic [7:0]   rd1;

  // Behavioural ALU. Non-arithmetic groups drive a junk carry-out so the
  // controller's carry masking is exercised.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] s, input logic cin);
    logic [4:0] r;
    case (s[3:2])
      2'b00: case (s[1:0])
        2'b00: r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        2'b01: r = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
        2'b10: r = {1'b0, a} + {4'b0, cin};
        default: r = {1'b0, a} + 5'h0F + {4'b0, cin};
      endcase
      2'b01: case (s[1:0])
        2'b00: r = {|a, a & b};
        2'b01: r = {|a, a | b};
        2'b10: r = {|a, a ^ b};
        default: r = {|a, ~a};
      endcase
      2'b10: r = {a[0], 1'b0, a[3:1]};
      default: r = {a[3], a[2:0], 1'b0};
    endcase
    return r;
  endfunction

  assign {cout0, y0} = alu_f(a0, b0, s0, cin0);
  assign {cout1, y1} = alu_f(a1, b1, s1, cin1);

  alu_mul_sequencer #(.W(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_mul(cmd_mul), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(a0), .alu_b(b0), .alu_s(s0),
    .alu_cin(cin0), .alu_y(y0), .alu_cout(cout0), .rsp_valid(rv0),
    .rsp_ready(rr0), .rsp_data(rd0), .rsp_err(re0));

  alu_mul_sequencer #(.W(W), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_mul(cmd_mul), .cmd_sel(cmd_sel), .cmd_cin(cmd_cin),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(a1), .alu_b(b1), .alu_s(s1),
    .alu_cin(cin1), .alu_y(y1), .alu_cout(cout1), .rsp_valid(rv1),
    .rsp_ready(rr1), .rsp_data(rd1), .rsp_err(re1));

  int unsigned passed = 0, total = 0;
  int unsigned hs_cyc = 0;
  logic [8:0]  sb0[$], sb1[$];

  // Called at a negedge with the target idle; returns at the negedge of
  // cycle 1 (handshake cycle = cycle 0).
  task automatic send(input bit nm, input logic mul, input logic [3:0] sel,
                      input logic cin, input logic [3:0] a, input logic [3:0] b,
                      input logic [8:0] exp);
    cmd_mul = mul; cmd_sel = sel; cmd_cin = cin; cmd_a = a; cmd_b = b;
    if (nm) begin v1 = 1'b1; sb1.push_back(exp); end
    else    begin v0 = 1'b1; sb0.push_back(exp); end
    hs_cyc = cyc;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic get_rsp(input bit nm, output int lat, output logic [8:0] got,
                         output bit to);
    for (int i = 0; i < 40 && !(nm ? rv1 : rv0); i++) @(negedge clk);
    to  = !(nm ? rv1 : rv0);
    lat = int'(cyc - hs_cyc);
    got = nm ? {re1, rd1} : {re0, rd0};
  endtask

  task automatic consume(input bit nm);
    if (nm) rr1 = 1'b1; else rr0 = 1'b1;
    @(negedge clk);
    rr0 = 1'b0; rr1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({rdy0, rv0, re0, rd0, a0, b0, s0, cin0} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0})
      $display("FAIL reset_state got rdy=%b rv=%b err=%b data=%h a=%h b=%h s=%b cin=%b required rdy=1 rest 0",
               rdy0, rv0, re0, rd0, a0, b0, s0, cin0);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_op;
    logic [20:0] tbl [8];
    int lat; logic [8:0] got, exp; bit to;
    // {sel, cin, a, b, expected rsp_data}
    tbl[0] = {4'b0000, 1'b0, 4'h9, 4'h8, 8'h11};
    tbl[1] = {4'b0100, 1'b0, 4'hC, 4'hA, 8'h08};
    tbl[2] = {4'b0001, 1'b1, 4'h5, 4'h3, 8'h12};
    tbl[3] = {4'b0011, 1'b0, 4'h0, 4'h0, 8'h0F};
    tbl[4] = {4'b1000, 1'b0, 4'h6, 4'h0, 8'h03};
    tbl[5] = {4'b1100, 1'b0, 4'h9, 4'h0, 8'h02};
    tbl[6] = {4'b0101, 1'b0, 4'hC, 4'h3, 8'h0F};
    tbl[7] = {4'b0010, 1'b1, 4'hF, 4'h0, 8'h10};
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 1'b0, tbl[i][20:17], tbl[i][16], tbl[i][15:12], tbl[i][11:8], {1'b0, tbl[i][7:0]});
      total++;
      if ({s0, cin0, a0, b0} !== tbl[i][20:8])
        $display("FAIL op%0d_alu_drive got s=%b cin=%b a=%h b=%h required %h", i, s0, cin0, a0, b0, tbl[i][20:8]);
      else passed++;
      get_rsp(1'b0, lat, got, to);
      exp = sb0.pop_front();
      total++;
      if (to || lat != 2) $display("FAIL op%0d_latency got %0d timeout=%0d required 2", i, lat, to);
      else passed++;
      total++;
      if (got !== exp) $display("FAIL op%0d_data got err/data %h required %h", i, got, exp);
      else passed++;
      consume(1'b0);
    end
  endtask

  task automatic test_multiply;
    logic [3:0] ma [6], mb [6];
    logic [3:0] exp_s;
    logic [7:0] p;
    int lat; logic [8:0] got, exp; bit to;
    ma[0] = 4'hF; mb[0] = 4'hF;
    ma[1] = 4'hB; mb[1] = 4'h3;
    ma[2] = 4'h7; mb[2] = 4'h0;
    for (int i = 3; i < 6; i++) begin
      ma[i] = 4'($urandom_range(15)); mb[i] = 4'($urandom_range(15));
    end
    for (int i = 0; i < 6; i++) begin
      p = {4'h0, ma[i]} * {4'h0, mb[i]};
      send(1'b0, 1'b1, 4'hF, 1'b1, ma[i], mb[i], {1'b0, p});
      for (int k = 0; k < 4; k++) begin
        exp_s = mb[i][k] ? 4'b0000 : 4'b0010;
        total++;
        if (s0 !== exp_s) $display("FAIL mul%0d_sel_iter%0d got %b required %b", i, k, s0, exp_s);
        else passed++;
        if (k < 3) @(negedge clk);
      end
      get_rsp(1'b0, lat, got, to);
      exp = sb0.pop_front();
      total++;
      if (to || lat != 5) $display("FAIL mul%0d_latency got %0d timeout=%0d required 5", i, lat, to);
      else passed++;
      total++;
      if (got !== exp) $display("FAIL mul%0d_product %h*%h got %h required %h", i, ma[i], mb[i], got, exp);
      else passed++;
      consume(1'b0);
    end
  endtask

  task automatic test_backpressure;
    int lat; logic [8:0] got, exp; bit to; bit stray;
    send(1'b0, 1'b0, 4'b0000, 1'b0, 4'h3, 4'h4, 9'h007);
    get_rsp(1'b0, lat, got, to);
    exp = sb0.pop_front();
    total++;
    if (to || got !== exp) $display("FAIL bp_first got %h timeout=%0d required %h", got, to, exp);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({rv0, rdy0, re0, rd0} !== {1'b1, 1'b0, 1'b0, 8'h07})
        $display("FAIL bp_hold%0d got rv=%b rdy=%b err=%b data=%h required rv=1 rdy=0 err=0 data=07",
                 k, rv0, rdy0, re0, rd0);
      else passed++;
      cmd_mul = 1'b1; cmd_a = 4'h5; cmd_b = 4'h5; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
    end
    consume(1'b0);
    total++;
    if ({rdy0, rv0, a0, b0, s0, cin0} !== {1'b1, 1'b0, 13'h0})
      $display("FAIL bp_idle got rdy=%b rv=%b a=%h b=%h s=%b cin=%b required rdy=1 rv=0 alu=0",
               rdy0, rv0, a0, b0, s0, cin0);
    else passed++;
    send(1'b0, 1'b0, 4'b0000, 1'b0, 4'h1, 4'h1, 9'h002);
    get_rsp(1'b0, lat, got, to);
    exp = sb0.pop_front();
    total++;
    if (to || lat != 2 || got !== exp)
      $display("FAIL bp_next got %h latency %0d timeout=%0d required %h latency 2", got, lat, to, exp);
    else passed++;
    consume(1'b0);
    stray = 1'b0;
    repeat (8) begin stray |= rv0; @(negedge clk); end
    total++;
    if (stray) $display("FAIL bp_ignored_cmd got stray response required none");
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat; logic [8:0] got, exp; bit to;
    int unsigned h0, h1, h2;
    send(1'b0, 1'b1, 4'h0, 1'b0, 4'h6, 4'h9, 9'h036);
    h0 = hs_cyc;
    get_rsp(1'b0, lat, got, to);
    exp = sb0.pop_front();
    total++;
    if (to || got !== exp) $display("FAIL b2b_mul got %h timeout=%0d required %h", got, to, exp);
    else passed++;
    consume(1'b0);
    send(1'b0, 1'b0, 4'b0110, 1'b0, 4'h6, 4'h3, 9'h005);
    h1 = hs_cyc;
    get_rsp(1'b0, lat, got, to);
    exp = sb0.pop_front();
    total++;
    if (to || got !== exp) $display("FAIL b2b_op got %h timeout=%0d required %h", got, to, exp);
    else passed++;
    consume(1'b0);
    send(1'b0, 1'b0, 4'b0000, 1'b1, 4'h0, 4'h0, 9'h001);
    h2 = hs_cyc;
    get_rsp(1'b0, lat, got, to);
    exp = sb0.pop_front();
    consume(1'b0);
    total++;
    if (to || got !== exp || h1 - h0 != 6 || h2 - h1 != 3)
      $display("FAIL b2b_spacing got gaps %0d,%0d data %h timeout=%0d required 6,3 data %h",
               h1 - h0, h2 - h1, got, to, exp);
    else passed++;
  endtask

  task automatic test_reset_mid_mul;
    int lat; logic [8:0] got, exp; bit stray;
    bit to;
    send(1'b0, 1'b1, 4'h0, 1'b0, 4'hA, 4'h5, 9'h032);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rdy0, rv0, re0, rd0, a0, b0, s0, cin0} !== {1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0})
      $display("FAIL async_reset got rdy=%b rv=%b err=%b data=%h a=%h b=%h s=%b cin=%b required rdy=1 rest 0",
               rdy0, rv0, re0, rd0, a0, b0, s0, cin0);
    else passed++;
    sb0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (8) begin stray |= rv0; @(negedge clk); end
    total++;
    if (stray) $display("FAIL reset_discard got response after reset required none");
    else passed++;
    send(1'b0, 1'b1, 4'h0, 1'b0, 4'hD, 4'hE, 9'h0B6);
    get_rsp(1'b0, lat, got, to);
    exp = sb0.pop_front();
    total++;
    if (to || lat != 5 || got !== exp)
      $display("FAIL post_reset_mul got %h latency %0d timeout=%0d required %h latency 5", got, lat, to, exp);
    else passed++;
    consume(1'b0);
  endtask

  task automatic test_mul_disabled;
    int lat; logic [8:0] got, exp; bit to;
    total++;
    if (rdy1 !== 1'b1) $display("FAIL nm_ready got %b required 1", rdy1);
    else passed++;
    send(1'b1, 1'b1, 4'h0, 1'b0, 4'h5, 4'h6, 9'h100);
    get_rsp(1'b1, lat, got, to);
    exp = sb1.pop_front();
    total++;
    if (to || lat != 1) $display("FAIL nm_err_latency got %0d timeout=%0d required 1", lat, to);
    else passed++;
    total++;
    if (got !== exp) $display("FAIL nm_err_rsp got err/data %h required %h", got, exp);
    else passed++;
    consume(1'b1);
    send(1'b1, 1'b0, 4'b0000, 1'b1, 4'h7, 4'h7, 9'h00F);
    get_rsp(1'b1, lat, got, to);
    exp = sb1.pop_front();
    total++;
    if (to || lat != 2 || got !== exp)
      $display("FAIL nm_op got %h latency %0d timeout=%0d required %h latency 2", got, lat, to, exp);
    else passed++;
    consume(1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_op();
    test_multiply();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_mul_disabled();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
